serv_wb_arbiter_seq: RTL and testbench
======================================

// Module: serv_wb_arbiter_seq
// PURPOSE
//  Registered two-master Wishbone arbiter. Shares one slow memory port (driven over
//  the TinyTapeout scanchain) between the SERV ibus (read-only) and dbus. Grant is
//  held for a whole transaction. Simultaneous requests are served round-robin.
//  An optional watchdog ends transactions that the external memory never acks.
// PARAMETERS
//  AW            32            address width
//  DW            32            data width (sel width = DW/8)
//  TIMEOUT       255           watchdog limit in cycles; 1..65535
//  TIMEOUT_DATA  32'hDEADBEEF  rdt returned on a watchdog-terminated transaction
// PORTS
//  clk            in   1     single clock (SERV clock domain)
//  reset_n        in   1     asynchronous reset, active-low
//  i_ibus_adr     in   AW    ibus address
//  i_ibus_cyc     in   1     ibus request
//  o_ibus_rdt     out  DW    ibus read data
//  o_ibus_ack     out  1     ibus ack
//  i_dbus_adr     in   AW    dbus address
//  i_dbus_dat     in   DW    dbus write data
//  i_dbus_sel     in   DW/8  dbus byte select
//  i_dbus_we      in   1     dbus write enable
//  i_dbus_cyc     in   1     dbus request
//  o_dbus_rdt     out  DW    dbus read data
//  o_dbus_ack     out  1     dbus ack
//  o_mem_adr      out  AW    memory address (registered)
//  o_mem_dat      out  DW    memory write data (registered)
//  o_mem_sel      out  DW/8  memory byte select (registered; all ones for ibus)
//  o_mem_we       out  1     memory write enable (registered; 0 for ibus)
//  o_mem_cyc      out  1     memory request (registered)
//  i_mem_rdt      in   DW    memory read data
//  i_mem_ack      in   1     memory ack
//  o_timeout      out  1     sticky watchdog flag (only when ARB_TIMEOUT_EN is defined)
// BEHAVIOUR
//  - Reset (reset_n low, async): state=IDLE, last=IBUS, all o_mem_* = 0, o_timeout = 0.
//  - FSM states:
//    - IDLE: both requests high -> grant the master that is not `last`.
//      One request high -> grant that master (G_IB or G_DB).
//      On the grant edge, latch that master's adr/dat/sel/we into o_mem_* and set
//      o_mem_cyc=1. Request-to-o_mem_cyc latency is 1 cycle.
//    - G_IB / G_DB: o_mem_* held stable. Ack is combinational:
//      o_<m>_ack = i_mem_ack & granted(m) & i_<m>_cyc.
//      o_<m>_rdt = i_mem_rdt whenever granted, else 0.
//      On the ack cycle: next state IDLE, o_mem_cyc cleared on the next edge, `last`
//      updated to the granted master.
//  - Turnaround: at least 1 IDLE cycle between transactions. Back-to-back requests
//    see a 2-cycle gap between ack and the next o_mem_cyc.
//  - Abort: the granted master drops cyc before ack -> IDLE next cycle, o_mem_cyc=0,
//    no ack issued, `last` not updated.
//  - An i_mem_ack in IDLE is ignored. An i_mem_ack in the same cycle as an abort is
//    dropped.
//  - The non-granted master sees ack=0 and rdt=0 and waits. It is never starved,
//    because round-robin alternates on contention.
//  - Address/data changes by a master while it is granted are ignored (values were
//    latched at grant).
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//  - A counter of width $clog2(TIMEOUT+1) clears on grant and increments each cycle
//    in G_IB/G_DB without i_mem_ack.
//  - When the count reaches TIMEOUT, the arbiter issues ack to the granted master
//    with rdt=TIMEOUT_DATA, goes to IDLE next cycle and sets o_timeout. o_timeout is
//    cleared only by reset.
//  - A real i_mem_ack in the same cycle takes priority: normal data is returned and
//    o_timeout is not set.
//  ARB_TIMEOUT_EN undefined:
//  - No counter. A transaction waits forever. o_timeout is tied to 0.
// TESTING
//  - Reset mid-transaction: assert reset_n=0 while in G_DB -> o_mem_cyc=0 and
//    o_dbus_ack=0 immediately (async); state IDLE after release.
//  - Single ibus read, adr=0x100: o_mem_cyc rises 1 cycle after i_ibus_cyc.
//    Expect o_mem_sel=4'hF and o_mem_we=0. With i_mem_ack after 3 cycles and
//    rdt=0x00000013 -> o_ibus_ack for 1 cycle with rdt=0x13.
//  - Simultaneous ibus+dbus after reset (last=IBUS) -> dbus granted first: write,
//    adr=0x2000, dat=0xCAFEF00D, sel=4'h3. After ack, ibus is granted 2 cycles later.
//    Then repeat the contention -> ibus is granted first.
//  - Abort: dbus drops cyc 2 cycles into its grant -> o_mem_cyc=0 next cycle. A late
//    i_mem_ack produces no ack on either bus. `last` is unchanged, so the next
//    contention grants dbus.
//  - ARB_TIMEOUT_EN with TIMEOUT=8 and memory never acking -> o_dbus_ack with
//    rdt=0xDEADBEEF exactly 8 cycles after grant, and o_timeout=1 stays high.
//  - ARB_TIMEOUT_EN with TIMEOUT=8 and i_mem_ack in cycle 8 -> real data is returned
//    and o_timeout stays 0.

Source files
------------

// File: rtl/serv_wb_arbiter_seq.sv
// serv_wb_arbiter_seq
// Registered two-master Wishbone arbiter sharing one slow memory port between
// the SERV ibus (read-only) and dbus. Grant is held for a whole transaction;
// contention is resolved round-robin against the last master served.
// Define ARB_TIMEOUT_EN to add a watchdog that terminates transactions the
// memory never acks (rdt = TIMEOUT_DATA, sticky o_timeout).
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no transaction; pick next master on this edge
// G_IB  | ibus owns the memory port until ack, abort or watchdog
// G_DB  | dbus owns the memory port until ack, abort or watchdog
module serv_wb_arbiter_seq #(
  parameter int            AW           = 32,
  parameter int            DW           = 32,
  parameter int            TIMEOUT      = 255,
  parameter logic [DW-1:0] TIMEOUT_DATA = DW'(32'hDEADBEEF)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   i_ibus_adr,
  input  logic            i_ibus_cyc,
  output logic [DW-1:0]   o_ibus_rdt,
  output logic            o_ibus_ack,
  input  logic [AW-1:0]   i_dbus_adr,
  input  logic [DW-1:0]   i_dbus_dat,
  input  logic [DW/8-1:0] i_dbus_sel,
  input  logic            i_dbus_we,
  input  logic            i_dbus_cyc,
  output logic [DW-1:0]   o_dbus_rdt,
  output logic            o_dbus_ack,
  output logic [AW-1:0]   o_mem_adr,
  output logic [DW-1:0]   o_mem_dat,
  output logic [DW/8-1:0] o_mem_sel,
  output logic            o_mem_we,
  output logic            o_mem_cyc,
  input  logic [DW-1:0]   i_mem_rdt,
  input  logic            i_mem_ack,
  output logic            o_timeout
);

  if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
    $error("serv_wb_arbiter_seq: TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G_IB = 2'd1,
    G_DB = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_db_q;   // 0: ibus served last, 1: dbus served last
  logic          grant_ib, grant_db;
  logic          gnt_ib, gnt_db;
  logic          cyc_gnt;
  logic          tmo_hit;
  logic          ack_any;
  logic          done;
  logic          abort;
  logic [DW-1:0] rdt_mux;

  assign gnt_ib  = (state_q == G_IB);
  assign gnt_db  = (state_q == G_DB);
  assign cyc_gnt = (gnt_ib & i_ibus_cyc) | (gnt_db & i_dbus_cyc);
  assign ack_any = i_mem_ack | tmo_hit;
  assign done    = cyc_gnt & ack_any;
  assign abort   = (gnt_ib | gnt_db) & ~cyc_gnt;

  // a real memory ack always wins over the watchdog
  assign rdt_mux = (tmo_hit & ~i_mem_ack) ? TIMEOUT_DATA : i_mem_rdt;

  assign o_ibus_ack = gnt_ib & i_ibus_cyc & ack_any;
  assign o_dbus_ack = gnt_db & i_dbus_cyc & ack_any;
  assign o_ibus_rdt = gnt_ib ? rdt_mux : '0;
  assign o_dbus_rdt = gnt_db ? rdt_mux : '0;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next state and grant strobes; contention goes to the master not served last
  always_comb begin
    state_d  = state_q;
    grant_ib = 1'b0;
    grant_db = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_dbus_cyc && (!i_ibus_cyc || !last_db_q)) begin
          state_d  = G_DB;
          grant_db = 1'b1;
        end else if (i_ibus_cyc) begin
          state_d  = G_IB;
          grant_ib = 1'b1;
        end
      end
      G_IB, G_DB: begin
        if (done || abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // round-robin history; only completed transactions count, aborts do not
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  last_db_q <= 1'b0;
    else if (done) last_db_q <= gnt_db;
  end

  // memory port registers; captured on grant and held for the transaction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_mem_adr <= '0;
      o_mem_dat <= '0;
      o_mem_sel <= '0;
      o_mem_we  <= 1'b0;
      o_mem_cyc <= 1'b0;
    end else if (grant_db) begin
      o_mem_adr <= i_dbus_adr;
      o_mem_dat <= i_dbus_dat;
      o_mem_sel <= i_dbus_sel;
      o_mem_we  <= i_dbus_we;
      o_mem_cyc <= 1'b1;
    end else if (grant_ib) begin
      o_mem_adr <= i_ibus_adr;
      o_mem_dat <= '0;
      o_mem_sel <= '1;
      o_mem_we  <= 1'b0;
      o_mem_cyc <= 1'b1;
    end else if (done || abort) begin
      o_mem_cyc <= 1'b0;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt_q;   // cycles left before the watchdog fires
  logic          timeout_q;

  assign tmo_hit   = (gnt_ib | gnt_db) & (tmo_cnt_q == '0);
  assign o_timeout = timeout_q;

  // watchdog down-counter, reloaded on every grant, fires at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
    end else if (grant_ib || grant_db) begin
      tmo_cnt_q <= CW'(TIMEOUT);
    end else if ((gnt_ib || gnt_db) && !i_mem_ack && (tmo_cnt_q != '0)) begin
      tmo_cnt_q <= tmo_cnt_q - CW'(1);
    end
  end

  // sticky flag: set only when the watchdog actually ended a transaction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              timeout_q <= 1'b0;
    else if (tmo_hit && !i_mem_ack && cyc_gnt) timeout_q <= 1'b1;
  end
`else
  assign tmo_hit   = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_serv_wb_arbiter_seq.sv
// Bench for serv_wb_arbiter_seq: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the arbiter.
module tb_serv_wb_arbiter_seq;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  localparam int TMO    = 8;
`else
  localparam bit TMO_EN = 1'b0;
  localparam int TMO    = 255;
`endif
  localparam logic [31:0] TDATA = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic [31:0] o_mem_adr;
  logic [31:0] o_mem_dat;
  logic [3:0]  o_mem_sel;
  logic        o_mem_we;
  logic        o_mem_cyc;
  logic [31:0] i_mem_rdt;
  logic        i_mem_ack;
  logic        o_timeout;

  always #5 clk = ~clk;

  serv_wb_arbiter_seq #(
    .AW(AW), .DW(DW), .TIMEOUT(TMO), .TIMEOUT_DATA(TDATA)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc),
    .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
    .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel),
    .i_dbus_we(i_dbus_we), .i_dbus_cyc(i_dbus_cyc),
    .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
    .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat), .o_mem_sel(o_mem_sel),
    .o_mem_we(o_mem_we), .o_mem_cyc(o_mem_cyc),
    .i_mem_rdt(i_mem_rdt), .i_mem_ack(i_mem_ack), .o_timeout(o_timeout)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // transaction-level model: owner is 0 (none), 1 (ibus) or 2 (dbus)
  int          m_owner;
  int          m_last;
  int          m_wait;
  logic [31:0] m_adr;
  logic [31:0] m_dat;
  logic [3:0]  m_sel;
  logic        m_we;
  logic        m_tmo;
  logic        p_ib_ack;
  logic        p_db_ack;
  int          lat;
  logic        got;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_last  = 1;
    m_wait  = 0;
    m_adr   = '0;
    m_dat   = '0;
    m_sel   = '0;
    m_we    = 1'b0;
    m_tmo   = 1'b0;
  endtask

  task automatic check_outputs();
    logic        g_cyc;
    logic        wd;
    logic [31:0] rdt;
    g_cyc = (m_owner == 1) ? i_ibus_cyc : (m_owner == 2) ? i_dbus_cyc : 1'b0;
    wd    = TMO_EN && (m_owner != 0) && (m_wait >= TMO);
    rdt   = (wd && !i_mem_ack) ? TDATA : i_mem_rdt;
    p_ib_ack = (m_owner == 1) && g_cyc && (i_mem_ack || wd);
    p_db_ack = (m_owner == 2) && g_cyc && (i_mem_ack || wd);
    chk("mem_cyc",  32'(o_mem_cyc), 32'(m_owner != 0));
    chk("mem_adr",  o_mem_adr, m_adr);
    chk("mem_dat",  o_mem_dat, m_dat);
    chk("mem_sel",  32'(o_mem_sel), 32'(m_sel));
    chk("mem_we",   32'(o_mem_we), 32'(m_we));
    chk("ibus_ack", 32'(o_ibus_ack), 32'(p_ib_ack));
    chk("dbus_ack", 32'(o_dbus_ack), 32'(p_db_ack));
    chk("ibus_rdt", o_ibus_rdt, (m_owner == 1) ? rdt : 32'h0);
    chk("dbus_rdt", o_dbus_rdt, (m_owner == 2) ? rdt : 32'h0);
    chk("timeout",  32'(o_timeout), 32'(m_tmo));
  endtask

  task automatic model_edge();
    logic g_cyc;
    logic wd;
    int   pick;
    g_cyc = (m_owner == 1) ? i_ibus_cyc : (m_owner == 2) ? i_dbus_cyc : 1'b0;
    wd    = TMO_EN && (m_owner != 0) && (m_wait >= TMO);
    if (m_owner == 0) begin
      if (i_ibus_cyc && i_dbus_cyc) pick = 3 - m_last;
      else if (i_dbus_cyc)          pick = 2;
      else if (i_ibus_cyc)          pick = 1;
      else                          pick = 0;
      if (pick == 2) begin
        m_adr = i_dbus_adr; m_dat = i_dbus_dat; m_sel = i_dbus_sel; m_we = i_dbus_we;
      end else if (pick == 1) begin
        m_adr = i_ibus_adr; m_dat = '0; m_sel = 4'hF; m_we = 1'b0;
      end
      m_owner = pick;
      m_wait  = 0;
    end else if (!g_cyc) begin
      m_owner = 0;
    end else if (i_mem_ack || wd) begin
      m_last = m_owner;
      if (!i_mem_ack) m_tmo = 1'b1;
      m_owner = 0;
    end else begin
      m_wait++;
    end
  endtask

  task automatic settle();
    #3;
    check_outputs();
  endtask

  task automatic adv();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    adv();
  endtask

  task automatic drive_idle();
    i_ibus_adr = '0; i_ibus_cyc = 1'b0;
    i_dbus_adr = '0; i_dbus_dat = '0; i_dbus_sel = '0; i_dbus_we = 1'b0; i_dbus_cyc = 1'b0;
    i_mem_rdt  = '0; i_mem_ack  = 1'b0;
  endtask

  initial begin
    drive_idle();
    model_reset();
    p_ib_ack = 1'b0;
    p_db_ack = 1'b0;

    // reset state
    #2;
    chk("rst_mem_cyc", 32'(o_mem_cyc), 32'd0);
    chk("rst_mem_adr", o_mem_adr, 32'h0);
    chk("rst_mem_sel", 32'(o_mem_sel), 32'h0);
    chk("rst_timeout", 32'(o_timeout), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(); step();

    // single ibus read
    i_ibus_cyc = 1'b1; i_ibus_adr = 32'h100;
    settle(); chk("ib_lat0_cyc", 32'(o_mem_cyc), 32'd0); adv();
    settle();
    chk("ib_lat1_cyc", 32'(o_mem_cyc), 32'd1);
    chk("ib_sel", 32'(o_mem_sel), 32'hF);
    chk("ib_we", 32'(o_mem_we), 32'd0);
    chk("ib_adr", o_mem_adr, 32'h100);
    adv();
    step(); step();
    i_mem_ack = 1'b1; i_mem_rdt = 32'h13;
    settle();
    chk("ib_ack", 32'(o_ibus_ack), 32'd1);
    chk("ib_rdt", o_ibus_rdt, 32'h13);
    adv();
    i_ibus_cyc = 1'b0; i_mem_ack = 1'b0; i_mem_rdt = '0;
    settle();
    chk("ib_ack_drop", 32'(o_ibus_ack), 32'd0);
    chk("ib_cyc_clr", 32'(o_mem_cyc), 32'd0);
    adv();

    // contention, last = ibus -> dbus first
    i_ibus_cyc = 1'b1; i_ibus_adr = 32'h200;
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h2000; i_dbus_dat = 32'hCAFEF00D;
    i_dbus_sel = 4'h3; i_dbus_we = 1'b1;
    step();
    settle();
    chk("rr_db_adr", o_mem_adr, 32'h2000);
    chk("rr_db_dat", o_mem_dat, 32'hCAFEF00D);
    chk("rr_db_sel", 32'(o_mem_sel), 32'h3);
    chk("rr_db_we", 32'(o_mem_we), 32'd1);
    adv();
    i_mem_ack = 1'b1;
    settle();
    chk("rr_db_ack", 32'(o_dbus_ack), 32'd1);
    chk("rr_ib_wait_ack", 32'(o_ibus_ack), 32'd0);
    chk("rr_ib_wait_rdt", o_ibus_rdt, 32'h0);
    adv();
    i_mem_ack = 1'b0;
    settle(); chk("turn_gap", 32'(o_mem_cyc), 32'd0); adv();
    settle();
    chk("rr_ib_cyc", 32'(o_mem_cyc), 32'd1);
    chk("rr_ib_adr", o_mem_adr, 32'h200);
    adv();
    i_mem_ack = 1'b1; i_mem_rdt = 32'h55; i_ibus_adr = 32'h204;
    settle();
    chk("adr_held", o_mem_adr, 32'h200);
    chk("rr_ib_ack", 32'(o_ibus_ack), 32'd1);
    adv();
    i_ibus_cyc = 1'b0; i_mem_ack = 1'b0;
    step();
    settle(); chk("rr_db_again", o_mem_adr, 32'h2000); adv();
    i_mem_ack = 1'b1; step();
    i_dbus_cyc = 1'b0; i_mem_ack = 1'b0; step();

    // abort: first make ibus the last served master
    i_ibus_cyc = 1'b1; i_ibus_adr = 32'h300; step();
    i_mem_ack = 1'b1; step();
    i_ibus_cyc = 1'b0; i_mem_ack = 1'b0; step();
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h3000; i_dbus_dat = '0; i_dbus_sel = 4'hF; i_dbus_we = 1'b0;
    step(); step(); step();
    i_dbus_cyc = 1'b0; i_mem_ack = 1'b1;
    settle(); chk("abort_no_ack", 32'(o_dbus_ack), 32'd0); adv();
    settle();
    chk("abort_cyc_clr", 32'(o_mem_cyc), 32'd0);
    chk("late_ack_db", 32'(o_dbus_ack), 32'd0);
    chk("late_ack_ib", 32'(o_ibus_ack), 32'd0);
    adv();
    i_mem_ack = 1'b0;
    i_ibus_cyc = 1'b1; i_ibus_adr = 32'h400; i_dbus_cyc = 1'b1;
    step();
    settle(); chk("abort_last_kept", o_mem_adr, 32'h3000); adv();
    i_mem_ack = 1'b1; step();
    i_dbus_cyc = 1'b0; i_mem_ack = 1'b0; step();
    step();
    i_mem_ack = 1'b1; step();
    i_ibus_cyc = 1'b0; i_mem_ack = 1'b0; step();

    // asynchronous reset while dbus is granted
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h5000;
    step(); step();
    i_mem_ack = 1'b1;
    #1; chk("pre_rst_ack", 32'(o_dbus_ack), 32'd1);
    #1; reset_n = 1'b0;
    #1;
    chk("rst_async_cyc", 32'(o_mem_cyc), 32'd0);
    chk("rst_async_ack", 32'(o_dbus_ack), 32'd0);
    model_reset();
    @(posedge clk); #1;
    drive_idle();
    reset_n = 1'b1;
    settle(); chk("post_rst_idle", 32'(o_mem_cyc), 32'd0); adv();

`ifdef ARB_TIMEOUT_EN
    // watchdog fires when memory never acks
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h6000;
    step();
    got = 1'b0; lat = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      settle();
      if (o_dbus_ack) begin
        got = 1'b1; lat = k;
        chk("wd_rdt", o_dbus_rdt, TDATA);
      end
      adv();
    end
    chk("wd_fired", 32'(got), 32'd1);
    chk("wd_latency", 32'(lat), 32'd8);
    i_dbus_cyc = 1'b0;
    step(); step(); step();
    settle(); chk("wd_sticky", 32'(o_timeout), 32'd1); adv();
    reset_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    settle(); chk("wd_rst_clr", 32'(o_timeout), 32'd0); adv();
    // real ack in the watchdog cycle wins
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h6100;
    step();
    for (int k = 0; k < 8; k++) step();
    i_mem_ack = 1'b1; i_mem_rdt = 32'h12345678;
    settle();
    chk("wd_race_ack", 32'(o_dbus_ack), 32'd1);
    chk("wd_race_rdt", o_dbus_rdt, 32'h12345678);
    adv();
    i_dbus_cyc = 1'b0; i_mem_ack = 1'b0;
    step();
    settle(); chk("wd_race_flag", 32'(o_timeout), 32'd0); adv();
`else
    // without the watchdog a transaction waits as long as it takes
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h6000;
    step();
    for (int k = 0; k < 300; k++) step();
    settle();
    chk("no_wd_ack", 32'(o_dbus_ack), 32'd0);
    chk("no_wd_cyc", 32'(o_mem_cyc), 32'd1);
    adv();
    i_dbus_cyc = 1'b0; step();
`endif

    // random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      if (i_ibus_cyc) begin
        if (p_ib_ack) begin
          if ($urandom_range(3) != 0) i_ibus_cyc = 1'b0;
        end else if ($urandom_range(39) == 0) begin
          i_ibus_cyc = 1'b0;
        end
      end else if ($urandom_range(2) == 0) begin
        i_ibus_cyc = 1'b1;
      end
      if (i_dbus_cyc) begin
        if (p_db_ack) begin
          if ($urandom_range(3) != 0) i_dbus_cyc = 1'b0;
        end else if ($urandom_range(39) == 0) begin
          i_dbus_cyc = 1'b0;
        end
      end else if ($urandom_range(2) == 0) begin
        i_dbus_cyc = 1'b1;
      end
      i_ibus_adr = $urandom();
      i_dbus_adr = $urandom();
      i_dbus_dat = $urandom();
      i_dbus_sel = 4'($urandom());
      i_dbus_we  = 1'($urandom());
      i_mem_ack  = ($urandom_range(2) == 0);
      i_mem_rdt  = $urandom();
      step();
    end
    drive_idle();
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
